gcd_stein: RTL and testbench



---
 rtl/gcd_stein.sv | 95 +++++++++
 tb/tb_gcd_stein.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD engine with ready/valid handshakes on both sides.
// Defining GCD_CYCLES_EN adds the cycles_o port reporting REDUCE iterations per result.
module gcd_stein #(
  parameter int WIDTH = 8
`ifdef GCD_CYCLES_EN
  , localparam int CW = $clog2(2*WIDTH+2)
`endif
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
`ifdef GCD_CYCLES_EN
  output logic [CW-1:0]    cycles_o,
`endif
  output logic [WIDTH-1:0] gcd_o
);
  localparam int KW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d, gcd_q;
  logic [KW-1:0]    k_q;
  logic             valid_q, a_even, b_even, accept, zero_op, equal;
  assign a_even  = ~a_q[0];
  assign b_even  = ~b_q[0];
  assign accept  = valid_i && state_q == IDLE;
  assign zero_op = a_i == '0 || b_i == '0;
  assign equal   = a_q == b_q;
  // one Stein step; the odd-odd case always subtracts the smaller operand
  assign a_d = a_even ? a_q >> 1 : (!b_even && a_q > b_q) ? (a_q - b_q) >> 1 : a_q;
  assign b_d = b_even ? b_q >> 1 : (!a_even && a_q <= b_q) ? (b_q - a_q) >> 1 : b_q;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      gcd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q <= a_i;
          b_q <= b_i;
          k_q <= '0;
          if (zero_op) begin
            gcd_q   <= a_i | b_i;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= REDUCE;
          end
        end
        REDUCE: if (equal) begin
          gcd_q   <= a_q << k_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
          k_q <= k_q + KW'(a_even & b_even);
        end
        DONE: if (ready_i) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef GCD_CYCLES_EN
  logic [CW-1:0] cyc_q, cyc_d, cycles_q;
  assign cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cyc_q    <= '0;
      cycles_q <= '0;
    end else if (accept) begin
      cyc_q <= '0;
      if (zero_op) cycles_q <= '0;
    end else if (state_q == REDUCE) begin
      cyc_q <= cyc_d;
      if (equal) cycles_q <= cyc_d;
    end
  end
  assign cycles_o = cycles_q;
`endif
  assign ready_o = state_q == IDLE;
  assign valid_o = valid_q;
  assign gcd_o   = gcd_q;
endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: scoreboard bench for gcd_stein at WIDTH=8 (directed table + random) and WIDTH=16 (random).
module tb_gcd_stein;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic        v8 = 0, rdo8, vo8, rdy8, hold8 = 1, rr8 = 1;
  logic [7:0]  a8 = 0, b8 = 0, go8;
  logic        v16 = 0, rdo16, vo16, rdy16, rr16 = 1;
  logic [15:0] a16 = 0, b16 = 0, go16;
  logic        rnd = 0;
`ifdef GCD_CYCLES_EN
  logic [4:0]  co8;
  logic [5:0]  co16;
`endif
  assign rdy8  = rnd ? rr8 : hold8;
  assign rdy16 = rnd ? rr16 : 1'b1;
  always @(posedge clk) begin
    #1;
    rr8  = 1'($urandom_range(0, 1));
    rr16 = 1'($urandom_range(0, 1));
  end
  gcd_stein #(.WIDTH(8)) dut8 (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(v8), .ready_o(rdo8), .a_i(a8), .b_i(b8),
    .valid_o(vo8), .ready_i(rdy8),
`ifdef GCD_CYCLES_EN
    .cycles_o(co8),
`endif
    .gcd_o(go8));
  gcd_stein #(.WIDTH(16)) dut16 (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(v16), .ready_o(rdo16), .a_i(a16), .b_i(b16),
    .valid_o(vo16), .ready_i(rdy16),
`ifdef GCD_CYCLES_EN
    .cycles_o(co16),
`endif
    .gcd_o(go16));
  int ncmp = 0, nfail = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  function automatic logic [31:0] gref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  // scoreboard: g=gcd, c=cycles (all ones = unchecked), l=exact latency (-1 = bound only), t=accept stamp
  typedef struct {logic [31:0] g; logic [31:0] c; int l; int t;} exp_t;
  exp_t q8[$], q16[$], e8, e16;
  logic [31:0] eg8, ec8, eg16, ec16;
  int el8, el16;
  bit seen8 = 0, hand8 = 0, seen16 = 0, hand16 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete(); seen8 = 0; hand8 = 0;
    end else begin
      if (hand8) begin chk("handoff_idle8", {30'b0, vo8, rdo8}, 32'd1); hand8 = 0; end
      if (v8 && rdo8) q8.push_back('{eg8, ec8, el8, cyc});
      if (vo8 && !seen8) begin
        seen8 = 1;
        chk("result_expected8", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          if (q8[0].l >= 0) chk("latency8", cyc - q8[0].t, q8[0].l);
          else chk("latency_bound8", 32'(cyc - q8[0].t <= 17), 32'd1);
        end
      end
      if (vo8 && rdy8 && q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("gcd8", 32'(go8), e8.g);
`ifdef GCD_CYCLES_EN
        if (e8.c != '1) chk("cycles8", 32'(co8), e8.c);
`endif
        seen8 = 0; hand8 = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete(); seen16 = 0; hand16 = 0;
    end else begin
      if (hand16) begin chk("handoff_idle16", {30'b0, vo16, rdo16}, 32'd1); hand16 = 0; end
      if (v16 && rdo16) q16.push_back('{eg16, ec16, el16, cyc});
      if (vo16 && !seen16) begin
        seen16 = 1;
        chk("result_expected16", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) chk("latency_bound16", 32'(cyc - q16[0].t <= 33), 32'd1);
      end
      if (vo16 && rdy16 && q16.size() != 0) begin
        e16 = q16.pop_front();
        chk("gcd16", 32'(go16), e16.g);
        seen16 = 0; hand16 = 1;
      end
    end
  end
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] g, input logic [31:0] c, input int l);
    int n = 0;
    @(posedge clk); #1;
    if (d == 0) begin a8 = a[7:0]; b8 = b[7:0]; eg8 = g; ec8 = c; el8 = l; v8 = 1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; eg16 = g; ec16 = c; el16 = l; v16 = 1; end
    while (!(d == 0 ? rdo8 : rdo16) && n < 200) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    if (d == 0) v8 = 0; else v16 = 0;
  endtask
  task automatic drain(input int d);
    int n = 0;
    while ((d == 0 ? (q8.size() != 0 || vo8) : (q16.size() != 0 || vo16)) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_wait", 32'(n < 300), 32'd1);
  endtask
  typedef struct {int a; int b; int g; int c;} vec_t;
  vec_t tv[11] = '{'{6, 2, 2, 3}, '{9, 12, 3, 4}, '{18, 12, 6, 4}, '{0, 7, 7, 0}, '{7, 0, 7, 0},
                   '{0, 0, 0, 0}, '{5, 5, 5, 1}, '{255, 1, 1, 8}, '{128, 64, 64, 8},
                   '{1, 1, 1, 1}, '{255, 255, 255, 1}};
  initial begin
    #900000;
    $display("FAIL watchdog: run still active, required to finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    v8 = 1; a8 = 5; b8 = 10;
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready", 32'(rdo8), 32'd1);
      chk("reset_valid", 32'(vo8), 32'd0);
      chk("reset_gcd", 32'(go8), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1; v8 = 0;
    @(negedge clk);
    chk("no_accept_in_reset", {30'b0, vo8, rdo8}, 32'd1);
    foreach (tv[i]) begin
      issue(0, tv[i].a, tv[i].b, tv[i].g, tv[i].c, (tv[i].a == 0 || tv[i].b == 0) ? 1 : tv[i].c + 1);
      drain(0);
    end
    hold8 = 0;
    issue(0, 12, 18, 6, 4, 5);
    n = 0;
    while (!vo8 && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid_wait", 32'(n < 50), 32'd1);
    v8 = 1; a8 = 3; b8 = 9;
    repeat (10) begin
      @(negedge clk);
      chk("bp_gcd", 32'(go8), 32'd6);
      chk("bp_valid", 32'(vo8), 32'd1);
      chk("bp_ready", 32'(rdo8), 32'd0);
    end
    @(posedge clk); #1;
    v8 = 0; hold8 = 1;
    drain(0);
    @(negedge clk);
    chk("gcd_hold_idle", 32'(go8), 32'd6);
    issue(0, 255, 1, 1, 8, 9);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("abort_idle", {30'b0, vo8, rdo8}, 32'd1);
    n = 0;
    repeat (20) begin @(negedge clk); if (vo8) n++; end
    chk("abort_no_result", n, 0);
    issue(0, 9, 12, 3, 4, 5);
    drain(0);
    rnd = 1;
    fork
      for (int i = 0; i < 500; i++) begin
        logic [31:0] x, y;
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 255);
        if ($urandom_range(0, 15) == 0) x = 0;
        if ($urandom_range(0, 15) == 0) y = 0;
        issue(0, x, y, gref(x, y), '1, -1);
        drain(0);
      end
      for (int j = 0; j < 500; j++) begin
        logic [31:0] x, y;
        x = $urandom_range(0, 65535);
        y = $urandom_range(0, 65535);
        if ($urandom_range(0, 15) == 0) x = 0;
        if ($urandom_range(0, 15) == 0) y = 0;
        if ($urandom_range(0, 3) == 0) begin x = x & 32'h0FF0; y = y & 32'h0FF0; end
        issue(1, x, y, gref(x, y), '1, -1);
        drain(1);
      end
    join
    rnd = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
